redirect_ctrl: RTL and testbench
================================

Name: redirect_ctrl

Overview:
- Sits directly downstream of the two branch/jump execution units.
- Takes each unit's redirect (valid, target, ROB id) and keeps only the oldest mispredict.
- Registers the survivor and presents it to the frontend with a valid/ready handshake.
- Sends a one-cycle backend flush pulse carrying the offending ROB id. A commit-time exception flush overrides everything.

Parameters:
- PC_W, 64, width of redirect target PC.
- ROB_IDX_W, 6, ROB index width; the ROB id is {wrap bit, index}, ROB_IDX_W+1 bits.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- bju0_redirect_valid  in  1  redirect request from branch pipe 0
- bju0_redirect_target  in  PC_W  target PC from pipe 0
- bju0_robid  in  ROB_IDX_W+1  ROB id of the pipe-0 branch
- bju1_redirect_valid  in  1  redirect request from branch pipe 1
- bju1_redirect_target  in  PC_W  target PC from pipe 1
- bju1_robid  in  ROB_IDX_W+1  ROB id of the pipe-1 branch
- commit_flush  in  1  exception/interrupt flush from commit; highest priority
- fe_redirect_valid  out  1  pending redirect offered to frontend
- fe_redirect_target  out  PC_W  PC the frontend restarts fetch from
- fe_redirect_ready  in  1  frontend accepts redirect this cycle
- be_flush_valid  out  1  one-cycle pulse: kill all instructions younger than be_flush_robid
- be_flush_robid  out  ROB_IDX_W+1  ROB id of the redirecting branch (the branch itself survives)

Behaviour:
- Age rule: A is older than B iff (A.wrap==B.wrap ? A.idx<B.idx : A.idx>B.idx). Equal ids cannot occur. If they do, pipe 0 wins.
- Stage select (combinational): pick the older of the valid bju0/bju1 requests, giving candidate cand_valid/cand_target/cand_robid.
- State machine, two states:
  - IDLE: nothing pending.
  - PEND: pend_target and pend_robid are held and fe_redirect_valid=1.
- Accept rule for the candidate:
  - In IDLE, the candidate is always accepted.
  - In PEND, it is accepted only if it is older than pend_robid. A younger candidate is on the wrong path and is dropped silently.
  - This holds even in the cycle the pending redirect is handed over (fe_redirect_valid & fe_redirect_ready).
- Transitions:
  - IDLE -> PEND on accept.
  - PEND -> PEND on accept (pending is replaced with no bubble).
  - PEND -> IDLE on handshake with no accept.
  - PEND stays PEND on handshake with accept (the new redirect is offered next cycle).
- Latency: a request arriving in cycle N gives fe_redirect_valid=1 and be_flush_valid=1 in cycle N+1.
- be_flush_valid pulses exactly one cycle per accept. be_flush_robid is the accepted id.
- Back-to-back accepts in cycles N and N+1 give two pulses. The second id is older, so the backend flush window only widens.
- While in PEND, fe_redirect_target and the held id stay stable until the handshake or an older replacement.
- Frontend stall: fe_redirect_valid holds while fe_redirect_ready=0, for any number of cycles.
- commit_flush=1:
  - Next state is IDLE and all inputs that cycle are ignored.
  - Next cycle, fe_redirect_valid=0 and be_flush_valid=0.
  - The commit unit drives its own frontend and backend flush.
- Reset: state IDLE. fe_redirect_valid=0, be_flush_valid=0, fe_redirect_target=0, be_flush_robid=0. Reset mid-PEND discards the pending redirect.
- Wrap-around: ids across the wrap boundary compare by the age rule. Example: id {1,000001} is younger than {0,111110}.
- Targets pass through unmodified. There is no PC arithmetic and no alignment check.

Decomposition:
- Shared package (backend common pkg):
  - robid_t typedef, {wrap, idx}.
  - ROB_IDX_W constant.
  - is_older(a,b) function, reused by the ROB and the issue queues.
- One sub-module, redirect_age_sel: combinational two-input oldest-select producing cand_valid/target/robid. The FSM and output registers live in redirect_ctrl.

Test Plan:
- Single redirect: bju0 valid, target 0x8000_1000, robid {0,5}, fe_ready=1 -> next cycle fe_redirect_valid=1 with that target, be_flush pulse robid {0,5}; following cycle idle.
- Dual same-cycle: bju0 robid {0,9} target 0xA0, bju1 robid {0,3} target 0xB0 -> only pipe 1 forwarded (target 0xB0, flush robid {0,3}).
- Stall and replace: pending robid {0,20} with fe_ready=0 for 4 cycles; cycle 2 bju0 robid {0,12} -> target swaps, second flush pulse {0,12}. Cycle 3 bju1 robid {0,30} -> dropped, no pulse.
- Wrap compare: pending {0,62}; bju0 robid {1,1} -> dropped. Then bju1 robid {0,60} -> accepted.
- Handshake plus accept: PEND {0,10} with fe_ready=1 same cycle as bju0 {0,4} -> next cycle fe_redirect_valid=1 target of {0,4}. Same case with bju0 {0,15} -> next cycle IDLE.
- commit_flush during PEND with a simultaneous bju0 request -> next cycle fe_redirect_valid=0, no flush pulse. Reset asserted in PEND -> all outputs 0 next cycle.

Source files
------------

// File: rtl/redirect_ctrl_pkg.sv
// Shared backend definitions: ROB id layout and the wrap-aware age compare.
// Both the ROB and the issue queues use the same helpers.
package redirect_ctrl_pkg;

    localparam int ROB_IDX_W = 6;

    typedef struct packed {
        logic                 wrap;
        logic [ROB_IDX_W-1:0] idx;
    } robid_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } redir_state_e;

    // a is older than b. When the wrap bits differ, the larger index was
    // allocated before the ROB pointer wrapped around.
    function automatic logic is_older(input robid_t a, input robid_t b);
        if (a.wrap == b.wrap) begin
            return a.idx < b.idx;
        end
        return a.idx > b.idx;
    endfunction

endpackage

// File: rtl/redirect_age_sel.sv
// Combinational oldest-of-two select over the two branch pipes' redirects.
// Pipe 0 wins a tie, which only happens on identical ids.
module redirect_age_sel
    import redirect_ctrl_pkg::*;
#(
    parameter int PC_W = 64
) (
    input  logic            bju0_valid,
    input  logic [PC_W-1:0] bju0_target,
    input  robid_t          bju0_robid,
    input  logic            bju1_valid,
    input  logic [PC_W-1:0] bju1_target,
    input  robid_t          bju1_robid,
    output logic            cand_valid,
    output logic [PC_W-1:0] cand_target,
    output robid_t          cand_robid
);

    logic pick1;

    always_comb begin
        pick1       = bju1_valid && (!bju0_valid || is_older(bju1_robid, bju0_robid));
        cand_valid  = bju0_valid || bju1_valid;
        cand_target = pick1 ? bju1_target : bju0_target;
        cand_robid  = pick1 ? bju1_robid  : bju0_robid;
    end

endmodule

// File: rtl/redirect_ctrl.sv
// Keeps the oldest branch mispredict, offers it to the frontend and pulses a
// backend flush once per accepted redirect. commit_flush overrides all of it.
module redirect_ctrl #(
    parameter int PC_W      = 64,
    parameter int ROB_IDX_W = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 bju0_redirect_valid,
    input  logic [PC_W-1:0]      bju0_redirect_target,
    input  logic [ROB_IDX_W:0]   bju0_robid,
    input  logic                 bju1_redirect_valid,
    input  logic [PC_W-1:0]      bju1_redirect_target,
    input  logic [ROB_IDX_W:0]   bju1_robid,
    input  logic                 commit_flush,
    output logic                 fe_redirect_valid,
    output logic [PC_W-1:0]      fe_redirect_target,
    input  logic                 fe_redirect_ready,
    output logic                 be_flush_valid,
    output logic [ROB_IDX_W:0]   be_flush_robid
);

    import redirect_ctrl_pkg::*;

    logic            cand_valid;
    logic [PC_W-1:0] cand_target;
    robid_t          cand_robid;

    redir_state_e    state;
    logic [PC_W-1:0] pend_target;
    robid_t          pend_robid;
    logic            fe_valid_q;
    logic            flush_q;

    logic            accept;
    logic            handshake;

    redirect_age_sel #(
        .PC_W (PC_W)
    ) u_age_sel (
        .bju0_valid  (bju0_redirect_valid),
        .bju0_target (bju0_redirect_target),
        .bju0_robid  (robid_t'(bju0_robid)),
        .bju1_valid  (bju1_redirect_valid),
        .bju1_target (bju1_redirect_target),
        .bju1_robid  (robid_t'(bju1_robid)),
        .cand_valid  (cand_valid),
        .cand_target (cand_target),
        .cand_robid  (cand_robid)
    );

    // Frontend handshake: a redirect transfers in any cycle where
    // fe_redirect_valid and fe_redirect_ready are both high; valid and target
    // hold stable until then unless an older redirect replaces them.
    always_comb begin
        handshake = fe_valid_q && fe_redirect_ready;
        accept    = cand_valid && !commit_flush &&
                    ((state == ST_IDLE) || is_older(cand_robid, pend_robid));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            fe_valid_q  <= 1'b0;
            flush_q     <= 1'b0;
            pend_target <= '0;
            pend_robid  <= '0;
        end else if (commit_flush) begin
            state      <= ST_IDLE;
            fe_valid_q <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            flush_q <= accept;
            if (accept) begin
                // Younger candidates never reach here, so a replacement only
                // ever widens the backend flush window.
                state       <= ST_PEND;
                fe_valid_q  <= 1'b1;
                pend_target <= cand_target;
                pend_robid  <= cand_robid;
            end else if (handshake) begin
                state      <= ST_IDLE;
                fe_valid_q <= 1'b0;
            end
        end
    end

    assign fe_redirect_valid  = fe_valid_q;
    assign fe_redirect_target = pend_target;
    assign be_flush_valid     = flush_q;
    assign be_flush_robid     = pend_robid;

endmodule

// File: tb/tb_redirect_ctrl.sv
// Directed bench for redirect_ctrl: expected flush ids go through a
// scoreboard queue and are popped whenever the DUT pulses be_flush_valid.
module tb_redirect_ctrl;

    localparam int PC_W  = 64;
    localparam int RID_W = 7;

    logic              clock = 1'b0;
    logic              reset;
    logic              bju0_redirect_valid;
    logic [PC_W-1:0]   bju0_redirect_target;
    logic [RID_W-1:0]  bju0_robid;
    logic              bju1_redirect_valid;
    logic [PC_W-1:0]   bju1_redirect_target;
    logic [RID_W-1:0]  bju1_robid;
    logic              commit_flush;
    logic              fe_redirect_valid;
    logic [PC_W-1:0]   fe_redirect_target;
    logic              fe_redirect_ready;
    logic              be_flush_valid;
    logic [RID_W-1:0]  be_flush_robid;

    int checks = 0;
    int errors = 0;
    logic [RID_W-1:0] exp_q[$];

    always #5 clock = ~clock;

    redirect_ctrl #(.PC_W(PC_W), .ROB_IDX_W(6)) dut (
        .clock                (clock),
        .reset                (reset),
        .bju0_redirect_valid  (bju0_redirect_valid),
        .bju0_redirect_target (bju0_redirect_target),
        .bju0_robid           (bju0_robid),
        .bju1_redirect_valid  (bju1_redirect_valid),
        .bju1_redirect_target (bju1_redirect_target),
        .bju1_robid           (bju1_robid),
        .commit_flush         (commit_flush),
        .fe_redirect_valid    (fe_redirect_valid),
        .fe_redirect_target   (fe_redirect_target),
        .fe_redirect_ready    (fe_redirect_ready),
        .be_flush_valid       (be_flush_valid),
        .be_flush_robid       (be_flush_robid)
    );

    function automatic logic [RID_W-1:0] rid(input logic w, input int i);
        logic [5:0] idx;
        idx = i[5:0];
        return {w, idx};
    endfunction

    task automatic chk(input string tag, input logic [PC_W-1:0] obs, input logic [PC_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [RID_W-1:0] r0, input logic [PC_W-1:0] t0,
                         input logic v1, input logic [RID_W-1:0] r1, input logic [PC_W-1:0] t1,
                         input logic rdy, input logic cf);
        bju0_redirect_valid  = v0;
        bju0_robid           = r0;
        bju0_redirect_target = t0;
        bju1_redirect_valid  = v1;
        bju1_robid           = r1;
        bju1_redirect_target = t1;
        fe_redirect_ready    = rdy;
        commit_flush         = cf;
    endtask

    task automatic idle_in(input logic rdy);
        drive(1'b0, '0, '0, 1'b0, '0, '0, rdy, 1'b0);
    endtask

    // Advance one clock with the inputs already driven, then check the
    // outputs that result; a flush pulse pops the scoreboard.
    task automatic cycle(input string tag, input logic ev, input logic [PC_W-1:0] et,
                         input logic ef, input logic [RID_W-1:0] er);
        logic [RID_W-1:0] want;
        if (ef) exp_q.push_back(er);
        @(posedge clock);
        #1;
        chk({tag, ".fe_valid"}, PC_W'(fe_redirect_valid), PC_W'(ev));
        if (ev) chk({tag, ".fe_target"}, fe_redirect_target, et);
        chk({tag, ".flush_valid"}, PC_W'(be_flush_valid), PC_W'(ef));
        if (be_flush_valid) begin
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                chk({tag, ".flush_robid"}, PC_W'(be_flush_robid), PC_W'(want));
            end else begin
                chk({tag, ".flush_unexpected"}, PC_W'(be_flush_robid), '1);
            end
        end
    endtask

    initial begin
        logic [PC_W-1:0] x1, x2, x3;
        int stall;

        reset = 1'b1;
        idle_in(1'b0);
        repeat (2) @(posedge clock);
        #1;
        chk("reset.fe_valid", PC_W'(fe_redirect_valid), '0);
        chk("reset.fe_target", fe_redirect_target, '0);
        chk("reset.flush_valid", PC_W'(be_flush_valid), '0);
        chk("reset.flush_robid", PC_W'(be_flush_robid), '0);
        reset = 1'b0;

        // Single redirect, then handshake back to idle.
        drive(1'b1, rid(0, 5), 64'h8000_1000, 1'b0, '0, '0, 1'b1, 1'b0);
        cycle("single", 1'b1, 64'h8000_1000, 1'b1, rid(0, 5));
        idle_in(1'b1);
        cycle("single_hs", 1'b0, '0, 1'b0, '0);
        idle_in(1'b0);
        cycle("single_idle", 1'b0, '0, 1'b0, '0);

        // Both pipes in the same cycle: pipe 1 is older.
        drive(1'b1, rid(0, 9), 64'hA0, 1'b1, rid(0, 3), 64'hB0, 1'b0, 1'b0);
        cycle("dual", 1'b1, 64'hB0, 1'b1, rid(0, 3));
        idle_in(1'b1);
        cycle("dual_hs", 1'b0, '0, 1'b0, '0);

        // Identical ids: pipe 0 wins.
        drive(1'b1, rid(0, 7), 64'h70, 1'b1, rid(0, 7), 64'h71, 1'b0, 1'b0);
        cycle("tie", 1'b1, 64'h70, 1'b1, rid(0, 7));
        idle_in(1'b1);
        cycle("tie_hs", 1'b0, '0, 1'b0, '0);

        // Stall with an older replacement and a dropped younger request.
        x1 = {$urandom, $urandom};
        x2 = {$urandom, $urandom};
        x3 = {$urandom, $urandom};
        drive(1'b1, rid(0, 20), x1, 1'b0, '0, '0, 1'b0, 1'b0);
        cycle("stall_acc", 1'b1, x1, 1'b1, rid(0, 20));
        idle_in(1'b0);
        cycle("stall_hold", 1'b1, x1, 1'b0, '0);
        drive(1'b1, rid(0, 12), x2, 1'b0, '0, '0, 1'b0, 1'b0);
        cycle("stall_repl", 1'b1, x2, 1'b1, rid(0, 12));
        drive(1'b0, '0, '0, 1'b1, rid(0, 30), x3, 1'b0, 1'b0);
        cycle("stall_drop", 1'b1, x2, 1'b0, '0);
        stall = $urandom_range(1, 6);
        for (int i = 0; i < stall; i++) begin
            idle_in(1'b0);
            cycle("stall_long", 1'b1, x2, 1'b0, '0);
        end
        idle_in(1'b1);
        cycle("stall_hs", 1'b0, '0, 1'b0, '0);

        // Wrap compare: {1,1} is younger than {0,62}, {0,60} is older.
        drive(1'b0, '0, '0, 1'b1, rid(0, 62), 64'h620, 1'b0, 1'b0);
        cycle("wrap_acc", 1'b1, 64'h620, 1'b1, rid(0, 62));
        drive(1'b1, rid(1, 1), 64'h11, 1'b0, '0, '0, 1'b0, 1'b0);
        cycle("wrap_drop", 1'b1, 64'h620, 1'b0, '0);
        drive(1'b0, '0, '0, 1'b1, rid(0, 60), 64'h600, 1'b0, 1'b0);
        cycle("wrap_older", 1'b1, 64'h600, 1'b1, rid(0, 60));
        idle_in(1'b1);
        cycle("wrap_hs", 1'b0, '0, 1'b0, '0);

        // Handshake in the same cycle as an older accept: stays pending.
        drive(1'b1, rid(0, 10), 64'h100, 1'b0, '0, '0, 1'b0, 1'b0);
        cycle("hsacc_pend", 1'b1, 64'h100, 1'b1, rid(0, 10));
        drive(1'b1, rid(0, 4), 64'h40, 1'b0, '0, '0, 1'b1, 1'b0);
        cycle("hsacc_older", 1'b1, 64'h40, 1'b1, rid(0, 4));
        idle_in(1'b1);
        cycle("hsacc_hs", 1'b0, '0, 1'b0, '0);

        // Handshake with a younger request: goes idle.
        drive(1'b1, rid(0, 10), 64'h100, 1'b0, '0, '0, 1'b0, 1'b0);
        cycle("hsyng_pend", 1'b1, 64'h100, 1'b1, rid(0, 10));
        drive(1'b1, rid(0, 15), 64'h150, 1'b0, '0, '0, 1'b1, 1'b0);
        cycle("hsyng_idle", 1'b0, '0, 1'b0, '0);

        // commit_flush in PEND beats a simultaneous older request.
        drive(1'b1, rid(0, 10), 64'h100, 1'b0, '0, '0, 1'b0, 1'b0);
        cycle("cf_pend", 1'b1, 64'h100, 1'b1, rid(0, 10));
        drive(1'b1, rid(0, 2), 64'h20, 1'b0, '0, '0, 1'b0, 1'b1);
        cycle("cf_kill", 1'b0, '0, 1'b0, '0);
        drive(1'b0, '0, '0, 1'b1, rid(0, 1), 64'h10, 1'b0, 1'b1);
        cycle("cf_idle", 1'b0, '0, 1'b0, '0);

        // Reset while pending clears everything.
        drive(1'b1, rid(1, 33), 64'hDEAD_BEEF, 1'b0, '0, '0, 1'b0, 1'b0);
        cycle("rst_pend", 1'b1, 64'hDEAD_BEEF, 1'b1, rid(1, 33));
        reset = 1'b1;
        drive(1'b1, rid(1, 2), 64'h22, 1'b0, '0, '0, 1'b0, 1'b0);
        cycle("rst_mid", 1'b0, '0, 1'b0, '0);
        chk("rst_mid.fe_target", fe_redirect_target, '0);
        chk("rst_mid.flush_robid", PC_W'(be_flush_robid), '0);
        reset = 1'b0;
        idle_in(1'b0);
        cycle("rst_after", 1'b0, '0, 1'b0, '0);

        chk("scoreboard_empty", PC_W'(exp_q.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
